// File: rtl/cache_dfp_responder.sv
// Backing-memory responder for the cache DFP port: one line request at a time,
// fixed latency, single-cycle response, sticky protocol-violation flag.
module cache_dfp_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BITS  = 256,
   parameter int DEPTH      = 64,
   parameter int LATENCY    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] dfp_addr,
   input  logic                  dfp_read,
   input  logic                  dfp_write,
   input  logic [LINE_BITS-1:0]  dfp_wdata,
   output logic [LINE_BITS-1:0]  dfp_rdata,
   output logic                  dfp_resp,
   output logic                  busy,
   output logic                  proto_err
);

   localparam int OFS = $clog2(LINE_BITS / 8);
   localparam int IDX = $clog2(DEPTH);
   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic                  lat_write;
   logic [LINE_BITS-1:0]  lat_wdata;
   logic [LINE_BITS-1:0]  mem [DEPTH];

   logic                  req;
   logic [IDX-1:0]        req_idx;
   logic [IDX-1:0]        lat_idx;

   assign req     = dfp_read | dfp_write;
   assign req_idx = dfp_addr[OFS +: IDX];
   assign lat_idx = lat_addr[OFS +: IDX];

   // Response outputs are set on the edge entering RESP so they never depend
   // combinationally on the request inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         dfp_resp  <= 1'b0;
         dfp_rdata <= '0;
         busy      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         dfp_resp  <= 1'b0;
         dfp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_addr  <= dfp_addr;
                  lat_write <= dfp_write;
                  lat_wdata <= dfp_wdata;
                  cnt       <= CW'(LATENCY - 1);
                  busy      <= 1'b1;
                  if (dfp_read && dfp_write) begin
                     proto_err <= 1'b1;
                  end
                  if (LATENCY == 1) begin
                     state    <= RESP;
                     dfp_resp <= 1'b1;
                     if (!dfp_write) begin
                        dfp_rdata <= mem[req_idx];
                     end
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               // Dropping both requests is a legal abort and wins even on the last count.
               if (!req) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  if ((dfp_addr != lat_addr) || (dfp_write != lat_write)) begin
                     proto_err <= 1'b1;
                  end
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     state    <= RESP;
                     dfp_resp <= 1'b1;
                     if (!lat_write) begin
                        dfp_rdata <= mem[lat_idx];
                     end
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Writes land at the end of the RESP cycle, so a reset before then loses them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if ((state == RESP) && lat_write) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_cache_dfp_responder.sv
// Directed and randomized checks of cache_dfp_responder against a line-array
// reference model with transaction-level latency expectations.
module tb_cache_dfp_responder;

   localparam int LATENCY = 8;
   localparam int DEPTH   = 64;

   logic         clk;
   logic         rst_n;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic         busy;
   logic         proto_err;

   logic [255:0] model_mem [DEPTH];
   logic         exp_err;
   int           checks;
   int           errors;
   int           cyc;
   int           resp_cyc;

   cache_dfp_responder #(
      .ADDR_WIDTH(32),
      .LINE_BITS(256),
      .DEPTH(DEPTH),
      .LATENCY(LATENCY)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dfp_addr(dfp_addr),
      .dfp_read(dfp_read),
      .dfp_write(dfp_write),
      .dfp_wdata(dfp_wdata),
      .dfp_rdata(dfp_rdata),
      .dfp_resp(dfp_resp),
      .busy(busy),
      .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      exp_err = 1'b0;
   endtask

   // gkind: 0 none, 1 change address at cycle glitch, 2 flip op at cycle glitch
   task automatic transact(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wdata, input int gkind, input int glitch,
                           input logic [31:0] gaddr, input string tag);
      int           idx;
      int           got;
      logic         stray;
      logic         lat_wr;
      logic [255:0] exp_data;
      idx      = int'((addr / 32) % DEPTH);
      lat_wr   = wr;
      exp_data = lat_wr ? '0 : model_mem[idx];
      if (rd && wr) exp_err = 1'b1;
      dfp_addr  = addr;
      dfp_read  = rd;
      dfp_write = wr;
      dfp_wdata = wdata;
      got   = 0;
      stray = 1'b0;
      for (int k = 1; k <= LATENCY + 3 && got == 0; k++) begin
         @(posedge clk);
         if (gkind != 0 && k == glitch) begin
            #1;
            exp_err = 1'b1;
            if (gkind == 1) begin
               dfp_addr = gaddr;
            end else begin
               dfp_read  = wr;
               dfp_write = ~wr;
            end
         end
         @(negedge clk);
         if (dfp_resp === 1'b1) begin
            got      = k;
            resp_cyc = cyc;
         end else if (dfp_rdata !== '0) begin
            stray = 1'b1;
         end
      end
      chk(256'(got), 256'(LATENCY), {tag, " latency"});
      chk(dfp_rdata, exp_data, {tag, " rdata"});
      chk(256'(busy), 256'(1), {tag, " busy at resp"});
      chk(256'(proto_err), 256'(exp_err), {tag, " proto_err"});
      chk(256'(stray), 256'(0), {tag, " rdata idle"});
      @(posedge clk);
      #1;
      if (lat_wr) model_mem[idx] = wdata;
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
   endtask

   task automatic abort_txn(input logic [31:0] addr, input int n, input string tag);
      logic seen;
      dfp_addr  = addr;
      dfp_read  = 1'b1;
      dfp_write = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk(256'(busy), 256'(1), {tag, " busy before drop"});
      dfp_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk(256'(busy), 256'(0), {tag, " busy after drop"});
      seen = dfp_resp;
      repeat (LATENCY + 1) begin
         @(negedge clk);
         if (dfp_resp !== 1'b0) seen = 1'b1;
      end
      chk(256'(seen), 256'(0), {tag, " no resp"});
      chk(256'(proto_err), 256'(exp_err), {tag, " proto_err"});
   endtask

   task automatic reset_dut(input string tag);
      #1;
      rst_n     = 1'b0;
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
      #1;
      chk(256'(dfp_resp), 256'(0), {tag, " resp"});
      chk(dfp_rdata, 256'(0), {tag, " rdata"});
      chk(256'(busy), 256'(0), {tag, " busy"});
      chk(256'(proto_err), 256'(0), {tag, " proto_err"});
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int           w_cyc;
      int           r;
      int           ridx;
      logic         seen;
      logic [31:0]  raddr;
      logic [255:0] rdat;

      checks    = 0;
      errors    = 0;
      cyc       = 0;
      resp_cyc  = 0;
      dfp_addr  = '0;
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
      dfp_wdata = '0;
      rst_n     = 1'b1;
      clear_model();
      @(negedge clk);
      reset_dut("reset");

      transact(0, 1, 32'h0000_0040, {32{8'hA5}}, 0, 0, 0, "wr40");
      transact(1, 0, 32'h0000_0040, '0, 0, 0, 0, "rd40");

      transact(0, 1, 32'h0000_0080, {16{16'h1234}}, 0, 0, 0, "wb80");
      w_cyc = resp_cyc;
      transact(1, 0, 32'h0000_0080, '0, 0, 0, 0, "fetch80");
      chk(256'(resp_cyc - w_cyc), 256'(LATENCY + 1), "wb-fetch spacing");

      transact(1, 0, 32'h0000_0840, '0, 0, 0, 0, "alias840");
      transact(1, 0, 32'h0000_0060, '0, 0, 0, 0, "rd60 blank");

      abort_txn(32'h0000_0040, 3, "abort3");
      transact(1, 0, 32'h0000_0040, '0, 0, 0, 0, "rd after abort");
      abort_txn(32'h0000_0040, LATENCY - 1, "abort last");

      // Write interrupted by reset must not land and must not respond.
      dfp_addr  = 32'h0000_0040;
      dfp_wdata = {32{8'hAA}};
      dfp_write = 1'b1;
      repeat (4) @(posedge clk);
      reset_dut("mid-busy reset");
      seen = 1'b0;
      repeat (LATENCY + 2) begin
         @(negedge clk);
         if (dfp_resp !== 1'b0) seen = 1'b1;
      end
      chk(256'(seen), 256'(0), "mid-busy no resp");
      transact(1, 0, 32'h0000_0040, '0, 0, 0, 0, "rd40 after reset");

      transact(1, 1, 32'h0000_0000, {256{1'b1}}, 0, 0, 0, "dual");
      transact(1, 0, 32'h0000_0000, '0, 0, 0, 0, "rd0 after dual");

      reset_dut("reset2");
      transact(0, 1, 32'h0000_0100, {8{32'hCAFE_0001}}, 1, 3, 32'h0000_0120, "addr glitch");
      transact(1, 0, 32'h0000_0100, '0, 0, 0, 0, "rd glitch addr");
      transact(1, 0, 32'h0000_0120, '0, 0, 0, 0, "rd glitch other");

      reset_dut("reset3");
      transact(0, 1, 32'h0000_01C0, {8{32'h0BAD_F00D}}, 2, LATENCY - 1, 0, "op flip");
      transact(1, 0, 32'h0000_01C0, '0, 0, 0, 0, "rd op flip");

      for (int i = 0; i < 24; i++) begin
         r     = int'($urandom_range(0, 9));
         ridx  = int'($urandom_range(0, 7));
         raddr = ($urandom & ~32'h0000_07E0) | (32'(ridx) << 5);
         rdat  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (r < 4) transact(1, 0, raddr, rdat, 0, 0, 0, "rand rd");
         else if (r < 8) transact(0, 1, raddr, rdat, 0, 0, 0, "rand wr");
         else if (r == 8) transact(1, 1, raddr, rdat, 0, 0, 0, "rand dual");
         else abort_txn(raddr, int'($urandom_range(1, LATENCY - 1)), "rand abort");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
